// File: rtl/fetch_slot_buffer_pkg.sv
// Shared defaults and bundle entry type for the fetch slot buffer.
// QSLOTS default comes from the `QSLOTS macro when the build provides one.
`ifndef QSLOTS
`define QSLOTS 2
`endif

package fetch_slot_buffer_pkg;
  localparam int QSLOTS_DEF = `QSLOTS;
  localparam int IW_DEF     = 52;
  localparam int AW_DEF     = 32;

  // One buffered bundle: address, slot payloads (slot 0 in LSBs), per-slot valid mask.
  typedef struct packed {
    logic [AW_DEF-1:0]            pc;
    logic [QSLOTS_DEF*IW_DEF-1:0] ins;
    logic [QSLOTS_DEF-1:0]        sv;
  } entry_t;
endpackage

// File: rtl/fetch_slot_buffer_if.sv
// Fetch-side offer and queue-side slot handshake of the fetch slot buffer.
interface fetch_slot_buffer_if #(
  parameter int QSLOTS = 2,
  parameter int IW     = 52,
  parameter int AW     = 32
);
  logic                 flush;
  logic                 fetch_v;
  logic [AW-1:0]        fetch_pc;
  logic [QSLOTS*IW-1:0] fetch_ins;
  logic                 fetch_rdy;
  logic [QSLOTS-1:0]    slotv;
  logic [QSLOTS*IW-1:0] slot_ins;
  logic [AW-1:0]        slot_pc;
  logic [QSLOTS-1:0]    take;
  logic                 empty;

  modport master (
    output flush, fetch_v, fetch_pc, fetch_ins, take,
    input  fetch_rdy, slotv, slot_ins, slot_pc, empty
  );

  modport slave (
    input  flush, fetch_v, fetch_pc, fetch_ins, take,
    output fetch_rdy, slotv, slot_ins, slot_pc, empty
  );
endinterface

// File: rtl/fetch_slot_buffer.sv
// Holds fetched instruction bundles and hands their slots out in order.
// BUNDLE_PREFETCH_EN: two-entry buffer so the next bundle lands while the head drains.
module fetch_slot_buffer
  import fetch_slot_buffer_pkg::*;
#(
  parameter int QSLOTS = QSLOTS_DEF,
  parameter int IW     = IW_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  fetch_slot_buffer_if.slave  bus
);
`ifdef BUNDLE_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  entry_t            ent [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     cnt;
  logic [QSLOTS-1:0] head_sv, eff, nxt_sv;
  logic              blocked, full, accept, pop, held;

  function automatic logic [PW-1:0] adv(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign held    = (cnt != '0);
  assign head_sv = held ? ent[rd_ptr].sv : '0;

  // A slot may only be taken once every lower valid slot is taken in the same cycle.
  always_comb begin
    eff     = '0;
    blocked = 1'b0;
    for (int i = 0; i < QSLOTS; i++) begin
      eff[i] = bus.take[i] & head_sv[i] & ~blocked;
      if (head_sv[i] && !eff[i]) blocked = 1'b1;
    end
  end

  assign nxt_sv = head_sv & ~eff;
  assign pop    = held && (nxt_sv == '0);
  assign full   = (cnt == CW'(DEPTH));
  assign accept = bus.fetch_v && !full && !bus.flush;

  assign bus.fetch_rdy = !full;
  assign bus.slotv     = head_sv;
  assign bus.slot_ins  = held ? ent[rd_ptr].ins : '0;
  assign bus.slot_pc   = held ? ent[rd_ptr].pc  : '0;
  assign bus.empty     = (head_sv == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i].sv <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (held) ent[rd_ptr].sv <= nxt_sv;
      if (pop) rd_ptr <= adv(rd_ptr);
      // Accept only happens below depth, so wr_ptr never aliases a live head.
      if (accept) begin
        ent[wr_ptr].pc  <= bus.fetch_pc;
        ent[wr_ptr].ins <= bus.fetch_ins;
        ent[wr_ptr].sv  <= '1;
        wr_ptr          <= adv(wr_ptr);
      end
      cnt <= cnt + CW'(accept) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_fetch_slot_buffer.sv
// Scoreboard bench for fetch_slot_buffer: directed steps queue expectations, a negedge monitor checks them.
module tb_fetch_slot_buffer;
  import fetch_slot_buffer_pkg::*;
  localparam int QS = 2;
  localparam int IW = 52;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_slot_buffer_if #(.QSLOTS(QS), .IW(IW), .AW(AW)) bus ();
  fetch_slot_buffer #(.QSLOTS(QS), .IW(IW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string            nm;
    logic [QS-1:0]    sv;
    logic [AW-1:0]    pc;
    logic [QS*IW-1:0] ins;
    logic             e;
    logic             r;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  // Bundle payload pattern: slot 0 = pc, slot 1 = ~pc.
  function automatic logic [QS*IW-1:0] mk(input logic [AW-1:0] pc);
    logic [IW-1:0] s0;
    s0 = IW'(pc);
    return {~s0, s0};
  endfunction

  task automatic step(input logic r, f, fv, input logic [AW-1:0] pc, input logic [QS-1:0] tk,
                      input string nm, input logic [QS-1:0] esv, input logic [AW-1:0] epc,
                      input logic ee, er);
    exp_t x;
    @(posedge clk); #1;
    rst           = r;
    bus.flush     = f;
    bus.fetch_v   = fv;
    bus.fetch_pc  = pc;
    bus.fetch_ins = mk(pc);
    bus.take      = tk;
    x.nm  = nm;
    x.sv  = esv;
    x.pc  = epc;
    x.ins = (esv != '0) ? mk(epc) : '0;
    x.e   = ee;
    x.r   = er;
    q.push_back(x);
  endtask

  always @(negedge clk) begin : mon
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      if (bus.slotv !== x.sv || bus.slot_pc !== x.pc || bus.slot_ins !== x.ins ||
          bus.empty !== x.e || bus.fetch_rdy !== x.r) begin
        failures++;
        $display("FAIL %s: got sv=%b pc=%h ins=%h empty=%b rdy=%b, want sv=%b pc=%h ins=%h empty=%b rdy=%b",
                 x.nm, bus.slotv, bus.slot_pc, bus.slot_ins, bus.empty, bus.fetch_rdy,
                 x.sv, x.pc, x.ins, x.e, x.r);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0; bus.fetch_v = 1'b0; bus.fetch_pc = '0; bus.fetch_ins = '0; bus.take = '0;
    //   rst f  fv pc       take   name                    sv     pc       empty rdy
    step(1, 0, 0, 32'h0,   2'b00, "reset",                2'b00, 32'h0,   1, 1);
`ifdef BUNDLE_PREFETCH_EN
    step(0, 0, 1, 32'h100, 2'b00, "idle_accept",          2'b00, 32'h0,   1, 1);
    step(0, 0, 1, 32'h108, 2'b00, "head_100",             2'b11, 32'h100, 0, 1);
    step(0, 0, 1, 32'h110, 2'b11, "full_rdy_low",         2'b11, 32'h100, 0, 0);
    step(0, 0, 1, 32'h110, 2'b00, "head_108",             2'b11, 32'h108, 0, 1);
    step(0, 0, 0, 32'h0,   2'b10, "take_hi_ignored",      2'b11, 32'h108, 0, 0);
    step(0, 0, 0, 32'h0,   2'b01, "still_11",             2'b11, 32'h108, 0, 0);
    step(0, 0, 1, 32'h118, 2'b10, "partial_10",           2'b10, 32'h108, 0, 0);
    step(0, 0, 1, 32'h118, 2'b01, "head_110",             2'b11, 32'h110, 0, 1);
    step(0, 1, 1, 32'h120, 2'b10, "flush_issue",          2'b10, 32'h110, 0, 0);
    step(0, 0, 1, 32'h130, 2'b00, "flushed",              2'b00, 32'h0,   1, 1);
    step(0, 0, 1, 32'h138, 2'b11, "head_130",             2'b11, 32'h130, 0, 1);
    step(0, 0, 0, 32'h0,   2'b11, "head_138",             2'b11, 32'h138, 0, 1);
    step(0, 0, 0, 32'h0,   2'b00, "drained",              2'b00, 32'h0,   1, 1);
`else
    step(0, 0, 1, 32'h100, 2'b00, "idle_accept",          2'b00, 32'h0,   1, 1);
    step(0, 0, 0, 32'h0,   2'b10, "head_100",             2'b11, 32'h100, 0, 0);
    step(0, 0, 0, 32'h0,   2'b01, "take_hi_ignored",      2'b11, 32'h100, 0, 0);
    step(0, 0, 1, 32'h200, 2'b10, "drain_rdy_low",        2'b10, 32'h100, 0, 0);
    step(0, 0, 1, 32'h200, 2'b00, "popped_rdy",           2'b00, 32'h0,   1, 1);
    step(0, 0, 1, 32'h300, 2'b11, "head_200",             2'b11, 32'h200, 0, 0);
    step(0, 0, 1, 32'h300, 2'b00, "refill_rdy",           2'b00, 32'h0,   1, 1);
    step(0, 1, 1, 32'h400, 2'b01, "flush_issue",          2'b11, 32'h300, 0, 0);
    step(0, 0, 1, 32'h500, 2'b00, "flushed",              2'b00, 32'h0,   1, 1);
    step(0, 0, 0, 32'h0,   2'b01, "head_500",             2'b11, 32'h500, 0, 0);
    step(1, 0, 0, 32'h0,   2'b00, "rst_mid_drain",        2'b00, 32'h0,   1, 1);
    step(0, 0, 0, 32'h0,   2'b11, "post_rst_take_empty",  2'b00, 32'h0,   1, 1);
    step(0, 0, 0, 32'h0,   2'b00, "no_underflow",         2'b00, 32'h0,   1, 1);
`endif
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d expectations left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_slot_buffer.md
FETCH_SLOT_BUFFER -- requirements
Module: fetch_slot_buffer

Interface
REQ-001 SHALL have parameter QSLOTS, default `QSLOTS (2), slots per bundle.
REQ-002 SHALL have parameter IW, default 52, instruction slot width in bits.
REQ-003 SHALL have parameter AW, default 32, bundle address width.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 flush  in  1  redirect or branch miss; discard all buffered slots.
REQ-008 fetch_v  in  1  I-cache offers a bundle (cache hit).
REQ-009 fetch_pc  in  AW  address of offered bundle.
REQ-010 fetch_ins  in  QSLOTS*IW  offered bundle, slot 0 in LSBs.
REQ-011 fetch_rdy  out  1  buffer accepts the offered bundle this cycle.
REQ-012 slotv  out  QSLOTS  per-slot valid of head bundle.
REQ-013 slot_ins  out  QSLOTS*IW  head bundle instructions.
REQ-014 slot_pc  out  AW  head bundle address.
REQ-015 take  in  QSLOTS  slots consumed by the queue this cycle.
REQ-016 empty  out  1  no valid slot held.

Function
REQ-017 Accept SHALL occur when fetch_v && fetch_rdy && !flush; accepted bundle is written with all QSLOTS valid bits set.
REQ-018 A bundle accepted into an empty buffer SHALL appear on slotv/slot_ins/slot_pc the following cycle (latency 1).
REQ-019 Effective take SHALL be take & slotv; bits outside slotv are ignored.
REQ-020 Slots SHALL be consumed in order: a take bit for slot n is ignored while a lower-numbered slot is valid and not taken in the same cycle.
REQ-021 Effective take bits SHALL clear the matching slotv bits at the next edge.
REQ-022 When the head's last valid slot is taken, the head SHALL pop; the next entry, if present, becomes head next cycle with its own slotv.
REQ-023 fetch_rdy SHALL derive only from registered occupancy (no combinational path from take or fetch_v); fetch_rdy = !full.
REQ-024 Simultaneous accept and pop SHALL leave occupancy unchanged; entries advance in order, no slot lost or duplicated.
REQ-025 flush SHALL clear all entries at the next edge, with priority over concurrent accept and take; the offered bundle is dropped.
REQ-026 empty SHALL equal (slotv == 0) for the head entry.
REQ-027 Occupancy counter SHALL never exceed buffer depth nor underflow; pointers wrap modulo depth.

Reset
REQ-028 During rst: all entry valid bits 0, slotv 0, empty 1, fetch_rdy 1, slot_ins 0, slot_pc 0, pointers and counter 0.
REQ-029 rst asserted mid-drain SHALL discard all partially consumed bundles immediately.

Configuration
REQ-030 Macro BUNDLE_PREFETCH_EN defined: depth 2; a second bundle is accepted while the head drains.
REQ-031 BUNDLE_PREFETCH_EN undefined: depth 1; fetch_rdy high only when no valid slot is held at the clock edge; accept never overlaps drain.

Structure
REQ-032 QSLOTS, IW defaults and the bundle entry typedef (pc, ins, slot valid mask) SHALL live in the shared Gambit package.
REQ-033 SHALL be a single module with no sub-modules; entry storage is a small register array.

Verification
REQ-034 Reset release, fetch_v=1, pc=0x100 -> cycle+1 slotv=2'b11, slot_pc=0x100, empty=0.
REQ-035 Head slotv=2'b11, take=2'b10 -> ignored, slotv stays 2'b11; take=2'b01 -> slotv=2'b10; take=2'b10 -> pop, empty=1.
REQ-036 With BUNDLE_PREFETCH_EN: bundles 0x100, 0x108 accepted back-to-back -> fetch_rdy=0; take=2'b11 -> next cycle slot_pc=0x108, slotv=2'b11, fetch_rdy=1.
REQ-037 Full buffer, take=2'b11 and fetch_v=1 same cycle -> fetch_rdy=0 that cycle, bundle not accepted; accepted the following cycle.
REQ-038 Two bundles held, flush=1 with fetch_v=1 -> next cycle slotv=0, empty=1, fetch_rdy=1, offered bundle absent.
REQ-039 Without BUNDLE_PREFETCH_EN: slotv=2'b10 held, fetch_v=1 -> fetch_rdy=0; after take=2'b10 -> fetch_rdy=1 next cycle.
